mpsoc_msi_wb_ram: RTL and testbench

//  Synthesizable Wishbone B3 slave (responder) with on-chip word RAM; the endpoint that answers

---
 rtl/mpsoc_msi_wb_ram.sv | 155 +++++++++++++++
 tb/tb_mpsoc_msi_wb_ram.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_msi_wb_ram.sv
// Wishbone B3 slave backed by an on-chip word RAM.
// Supports classic cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16).
module mpsoc_msi_wb_ram #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned MEM_SIZE_BYTES = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o
);

  localparam int unsigned BYTE_AW = $clog2(MEM_SIZE_BYTES);
  localparam int unsigned IDX_W   = BYTE_AW - 2;
  localparam int unsigned DEPTH   = MEM_SIZE_BYTES / 4;
  localparam int unsigned LANES   = DW / 8;

  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE_BYTES);
  localparam logic [2:0]    CTI_INCR  = 3'b010;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [DW-1:0]    mem [DEPTH];

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [1:0]       bte_q;
  logic [1:0]       bte_n;
  logic             ack_n;
  logic             err_n;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;

  logic             req;
  logic             oor;
  logic             wr_en;
  logic [AW-1:0]    na;
  logic             na_oor;
  logic [IDX_W-1:0] wr_idx;

  // Burst address advance: only the wrap-window bits increment, upper bits are preserved.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    inc = a + AW'(4);
    case (bte)
      2'b01:   mask = AW'(32'h0000_000C);
      2'b10:   mask = AW'(32'h0000_001C);
      2'b11:   mask = AW'(32'h0000_003C);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign req    = wb_cyc_i & wb_stb_i;
  assign oor    = (wb_adr_i >= MEM_LIMIT);
  assign na     = next_adr(wb_adr_i, wb_bte_i);
  assign na_oor = (na >= MEM_LIMIT);
  assign wr_en  = req & wb_we_i & wb_ack_o;
  assign wr_idx = wb_adr_i[BYTE_AW-1:2];

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    bte_n   = bte_q;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = wb_adr_i[BYTE_AW-1:2];
    case (state)
      S_IDLE: begin
        if (req) begin
          if (oor) begin
            err_n   = 1'b1;
            state_n = S_ACK;
          end else begin
            ack_n   = 1'b1;
            rd_en   = 1'b1;
            bte_n   = wb_bte_i;
            state_n = (wb_cti_i == CTI_INCR) ? S_BURST : S_ACK;
          end
        end
      end
      S_ACK: begin
        state_n = S_IDLE;
      end
      S_BURST: begin
        // Any break of the incrementing pattern (including end-of-burst) drops ack next cycle.
        state_n = S_IDLE;
        if (req && (wb_cti_i == CTI_INCR) && (wb_bte_i == bte_q)) begin
          if (na_oor) begin
            err_n   = 1'b1;
            state_n = S_ACK;
          end else begin
            ack_n   = 1'b1;
            rd_en   = 1'b1;
            rd_idx  = na[BYTE_AW-1:2];
            state_n = S_BURST;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and termination registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      bte_q    <= 2'b00;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      state    <= state_n;
      bte_q    <= bte_n;
      wb_ack_o <= ack_n;
      wb_err_o <= err_n;
    end
  end

  // Registered RAM read; a same-edge write is not visible, so old data is returned.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_dat_o <= '0;
    end else if (rd_en) begin
      wb_dat_o <= mem[rd_idx];
    end
  end

  // Byte-lane write on the acknowledged beat; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && wr_en) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wb_sel_i[b]) begin
          mem[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mpsoc_msi_wb_ram.sv
// Scoreboard bench for mpsoc_msi_wb_ram: classic, byte-lane, burst, wrap, range-error and reset cases.
module tb_mpsoc_msi_wb_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;

  always #5 clk = ~clk;

  mpsoc_msi_wb_ram #(.DW(32), .AW(32), .MEM_SIZE_BYTES(256)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err)
  );

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [64];
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] span;
    logic [31:0] base;
    if (b == 2'b00) return a + 32'd4;
    span = 32'd8 << b;
    base = a - (a % span);
    return base + ((a - base + 32'd4) % span);
  endfunction

  task automatic expect_rsp(input logic [31:0] a, input bit w, input logic [31:0] d,
                            input logic [3:0] s);
    exp_t e;
    e.is_err = (a >= 32'd256);
    e.is_rd  = !w;
    e.data   = '0;
    if (!e.is_err) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model[a[7:2]][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        e.data = model[a[7:2]];
      end
    end
    sb.push_back(e);
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    cti = 3'b000; bte = 2'b00; adr = '0; dat_i = '0;
  endtask

  task automatic wait_first(input string tag);
    int lat;
    for (lat = 0; lat < 8; lat++) begin
      @(negedge clk);
      if (ack || err) break;
    end
    check_eq(tag, 32'(lat), 32'd1);
  endtask

  task automatic wb_classic(input logic [31:0] a, input bit w, input logic [31:0] d,
                            input logic [3:0] s);
    @(posedge clk); #1;
    adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; cti = 3'b000; bte = 2'b00;
    expect_rsp(a, w, d, s);
    wait_first("classic_lat");
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check_eq("classic_drop", {30'b0, ack, err}, 32'd0);
  endtask

  task automatic wb_burst(input logic [31:0] a0, input logic [1:0] b, input int n,
                          input bit w, input logic [31:0] d0);
    logic [31:0] a;
    a = a0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      adr = a; dat_i = d0 + 32'(i); sel = 4'hF; we = w; cyc = 1'b1; stb = 1'b1; bte = b;
      cti = (i == n - 1) ? 3'b111 : 3'b010;
      expect_rsp(a, w, d0 + 32'(i), 4'hF);
      if (i == 0) begin
        wait_first("burst_lat");
      end else begin
        @(negedge clk);
        check_eq("burst_nobubble", {31'b0, ack | err}, 32'd1);
      end
      a = tb_next(a, b);
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check_eq("burst_drop", {30'b0, ack, err}, 32'd0);
  endtask

  // Every terminated beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", {30'b0, ack, err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rsp_ack_err", {30'b0, ack, err}, {30'b0, !mon_e.is_err, mon_e.is_err});
        if (mon_e.is_rd && !mon_e.is_err) check_eq("rsp_data", dat_o, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ack_err", {30'b0, ack, err}, 32'd0);
    check_eq("reset_dat", dat_o, 32'd0);

    // Classic write/read.
    wb_classic(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wb_classic(32'h10, 1'b0, 32'h0, 4'hF);

    // Byte lanes, including an empty select.
    wb_classic(32'h20, 1'b1, 32'h1122_3344, 4'hF);
    wb_classic(32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101);
    wb_classic(32'h20, 1'b0, 32'h0, 4'hF);
    check_eq("lane_model", model[8], 32'h11BB_33DD);
    wb_classic(32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    wb_classic(32'h20, 1'b0, 32'h0, 4'hF);

    // Linear bursts.
    wb_burst(32'h40, 2'b00, 4, 1'b1, 32'h4000_0000);
    wb_burst(32'h40, 2'b00, 4, 1'b0, 32'h0);

    // Wrap-4 read from mid-window.
    for (int i = 0; i < 4; i++) wb_classic(32'h30 + 32'(4*i), 1'b1, 32'h3000_0000 + 32'(i), 4'hF);
    wb_burst(32'h38, 2'b01, 4, 1'b0, 32'h0);

    // Wrap-8 write then linear read-back of the window.
    wb_burst(32'h54, 2'b10, 8, 1'b1, 32'h5400_0000);
    wb_burst(32'h40, 2'b00, 8, 1'b0, 32'h0);

    // Out of range: error, no aliasing into RAM.
    wb_classic(32'h00, 1'b1, 32'h0BAD_F00D, 4'hF);
    wb_classic(32'h100, 1'b0, 32'h0, 4'hF);
    wb_classic(32'h100, 1'b1, 32'hFFFF_0000, 4'hF);
    wb_classic(32'h00, 1'b0, 32'h0, 4'hF);

    // Burst running off the end of RAM.
    wb_classic(32'hF8, 1'b1, 32'hF8F8_F8F8, 4'hF);
    wb_classic(32'hFC, 1'b1, 32'hFCFC_FCFC, 4'hF);
    wb_burst(32'hF8, 2'b00, 3, 1'b0, 32'h0);

    // Reset during the third beat of a linear write burst.
    for (int i = 0; i < 4; i++) wb_classic(32'h80 + 32'(4*i), 1'b1, 32'hA000_0000 + 32'(i), 4'hF);
    @(posedge clk); #1;
    adr = 32'h80; dat_i = 32'hB000_0000; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    cti = 3'b010; bte = 2'b00;
    expect_rsp(32'h80, 1'b1, 32'hB000_0000, 4'hF);
    wait_first("rst_burst_lat");
    @(posedge clk); #1;
    adr = 32'h84; dat_i = 32'hB000_0001;
    expect_rsp(32'h84, 1'b1, 32'hB000_0001, 4'hF);
    @(negedge clk);
    check_eq("rst_burst_beat2", {31'b0, ack}, 32'd1);
    @(posedge clk); #1;
    adr = 32'h88; dat_i = 32'hB000_0002;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    @(negedge clk);
    check_eq("rst_mid_ack_err", {30'b0, ack, err}, 32'd0);
    check_eq("rst_mid_dat", dat_o, 32'd0);
    wb_classic(32'h80, 1'b0, 32'h0, 4'hF);
    wb_classic(32'h84, 1'b0, 32'h0, 4'hF);
    wb_classic(32'h88, 1'b0, 32'h0, 4'hF);
    check_eq("rst_no_commit_model", model[34], 32'hA000_0002);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
